// File: rtl/pdm_serializer_if.sv
// pdm_serializer_if: word handshake between a sample producer and pdm_serializer.
// The producer drives data/load; the serializer answers with ready.
`timescale 1ns/1ps
interface pdm_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             load;
    logic             ready;

    modport master (output data, output load, input ready);
    modport slave  (input data, input load, output ready);
endinterface

// File: rtl/pdm_serializer.sv
// pdm_serializer: shifts handshaked words out MSB-first with a divided bit clock.
// Define PDM_SERIALIZER_HOLD_BUF_EN for a one-word holding buffer (gapless streaming).
`timescale 1ns/1ps
module pdm_serializer #(
    parameter int CLK_DIV = 100,
    parameter int WIDTH   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    pdm_serializer_if.slave bus,
    output logic            data_out,
    output logic            pdm_clk_o,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] pend_data;
    logic             pend_valid;
    logic             slot_free;
    logic             tick;
    logic             last_bit;
    logic             accept;
    logic             start;

    assign tick     = enable && (cnt == CNT_MAX);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign accept   = bus.load && bus.ready;
    assign cnt_nx   = (!enable || tick) ? '0 : cnt + CW'(1);
    assign data_out = sreg[WIDTH-1];

    // A pending word starts from IDLE or chains directly onto the last bit.
    assign start = tick && pend_valid && ((state == IDLE) || last_bit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (tick && pend_valid) state_nx = SHIFT;
            SHIFT: if (tick && last_bit && !pend_valid) state_nx = IDLE;
        endcase
        if (!enable) state_nx = IDLE;
    end

    always_comb begin
        busy = (state == SHIFT);
`ifdef PDM_SERIALIZER_HOLD_BUF_EN
        slot_free = !pend_valid;
`else
        slot_free = !pend_valid && (state == IDLE);
`endif
        bus.ready = enable && slot_free && !reset;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            pdm_clk_o  <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
            sreg       <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            cnt       <= cnt_nx;
            // Registered from the next count so the bit clock tracks cnt exactly.
            pdm_clk_o <= (cnt_nx >= CNT_HALF);
            done      <= tick && (state == SHIFT) && last_bit;
            if (!enable) begin
                bit_cnt    <= '0;
                sreg       <= '0;
                pend_valid <= 1'b0;
                pend_data  <= '0;
            end else begin
                if (start) begin
                    sreg    <= pend_data;
                    bit_cnt <= '0;
                end else if (tick && (state == SHIFT)) begin
                    if (last_bit) begin
                        sreg    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        sreg    <= {sreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                if (accept) begin
                    pend_valid <= 1'b1;
                    pend_data  <= bus.data;
                end else if (start) begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/pdm_serializer.md
# pdm_serializer

- Transmit counterpart of the PDM Deserializer: accepts 16-bit words over a valid/ready handshake and shifts them out MSB-first on `data_out`.
- Generates its own bit clock `pdm_clk_o` by dividing the 100 MHz system clock (1 MHz by default).
- Sits between the sample-producing logic and an external PDM/serial sink, or a loopback Deserializer in test builds.

## Interface
- `CLK_DIV`, 100: system clocks per serial bit. Even, ≥4.
- `WIDTH`, 16: bits per word.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run/abort. Low forces idle.
- `data` in WIDTH: word to transmit.
- `load` in 1: `data` valid.
- `ready` out 1: word can be accepted this cycle.
- `data_out` out 1: serial bit stream.
- `pdm_clk_o` out 1: bit clock. The sink samples on its rising edge.
- `busy` out 1: a word is shifting.
- `done` out 1: one-cycle pulse when a word finishes.

## Operation
- **Divider.** `cnt` runs 0..CLK_DIV-1 while `enable`=1 and wraps to 0. It is held at 0 while `enable`=0.
- **Tick.** `tick` is the edge where `cnt` wraps from CLK_DIV-1 to 0. All bit-level state changes happen only at `tick`.
- **Bit clock.** `pdm_clk_o` comes from a flop and is glitch-free. It is 1 exactly while `cnt` ≥ CLK_DIV/2, so it falls at `tick` and rises mid-bit.
- **Handshake.** A word is accepted on a rising edge with `load`=1 and `ready`=1. `load` while `ready`=0 is ignored; no error is flagged and the word is dropped.
- **`ready`.** Combinational: `enable` AND slot free.
- **States.** IDLE and SHIFT.
- **IDLE.**
  - `data_out`=0 and `busy`=0.
  - An accepted word becomes pending.
  - At the next `tick`: load it into the shift register, drive bit WIDTH-1 on `data_out`, set `busy`, and go to SHIFT.
- **SHIFT.**
  - Each `tick` shifts left and drives the next lower bit. The bit counter runs 0..WIDTH-1.
  - At the `tick` ending bit 0, `done` pulses for the cycle following that edge. Then:
    - if a next word is pending, load it and drive its MSB at that same `tick`, with no gap bit;
    - otherwise return to IDLE with `data_out`=0.
- **Abort.** `enable` falling in any state aborts: go to IDLE, clear `cnt`, the shift register, and any pending word; drive `pdm_clk_o`=0 and `data_out`=0. No `done` is produced. Re-enabling starts from the first `cnt`=0.
- **Reset.** `reset` asserted mid-operation has the same effect as abort, applied asynchronously.
- **Simultaneous `load` and end-of-word `tick`.** With a free slot, the word is accepted. It is sent back-to-back only if it was accepted strictly before that `tick` edge; otherwise it starts at the next `tick`.

## Timing
- **Reset values:** `data_out`=0, `pdm_clk_o`=0, `busy`=0, `done`=0. `ready`=`enable` immediately after reset.
- **Start latency:** 1 to CLK_DIV cycles from acceptance to the MSB appearing, i.e. up to the next `tick`.
- **Bit period:** CLK_DIV cycles. Word period: WIDTH×CLK_DIV cycles.
- **`done`:** exactly one cycle, coincident with `cnt`=0 after the final bit.
- **Bit stability:** each bit is stable for CLK_DIV/2 cycles on both sides of the `pdm_clk_o` rising edge.

## Configuration
- Macro `PDM_SERIALIZER_HOLD_BUF_EN`.
- **Defined:** a one-word holding buffer exists. The slot is free when the buffer is empty, so `ready` stays high during SHIFT until a second word is held. Consecutive words stream with no gap.
- **Undefined:** no buffer. The slot is free only in IDLE with nothing pending, so `ready`=0 from acceptance until return to IDLE. Each word is followed by at least one idle bit period (`data_out`=0), and back-to-back streaming never occurs.

## Test plan
All scenarios use CLK_DIV=4 and WIDTH=16.
- **Reset.** Assert `reset` mid-word (bit 7 of 16'hFFFF) -> all outputs 0 immediately; no `done`; after release, `ready`=`enable`.
- **Single word.** `enable`=1, load 16'hA5C3 in IDLE -> `data_out` = 1010 0101 1100 0011, each bit held 4 cycles and aligned to the `pdm_clk_o` falling edge. `busy` is high for exactly 64 cycles. One `done` pulse follows.
- **Back-to-back (macro defined).** Load 16'h8001 then 16'h7FFE during the first word -> 32 contiguous bits 1000…0001 0111…1110, two `done` pulses 64 cycles apart, no gap bit.
- **Buffer disabled (macro undefined).** Same stimulus -> `ready`=0 throughout the first word; a second `load` in that window is ignored. After IDLE, a reload transmits with at least 4 cycles of `data_out`=0 between words.
- **Abort.** Drop `enable` at bit 3 of 16'hFFFF -> `pdm_clk_o`=0 and `data_out`=0 next cycle, `ready`=0, no `done`. Re-enable and load 16'h0001 -> clean 16-bit frame.
- **Loopback.** Connect `data_out`/`pdm_clk_o` to the Deserializer and send 100 random words -> every received word matches the transmitted one.
